// File: rtl/cdecv_pkg.sv
// cdecv_pkg: shared opcodes, FSM states, instruction layout and flag indices for the execute stage
package cdecv_pkg;
  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_ADC = 5'b01010;
  localparam logic [4:0] OP_SUB = 5'b01011;
  localparam logic [4:0] OP_SBC = 5'b01101;
  localparam logic [4:0] OP_INC = 5'b01110;
  localparam logic [4:0] OP_AND = 5'b10000;
  localparam logic [4:0] OP_SHL = 5'b11011;
  localparam int OP_W    = 5;
  localparam int WB_BIT  = 0;
  localparam int RS_LSB  = 1;
  localparam int FLAG_S  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_CY = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WRITE = 2'd3} state_e;
  // instr is {aluop, rd, rs, wb_en}; field positions scale with the register address width
  function automatic int rd_lsb(input int aw);
    return RS_LSB + aw;
  endfunction
  function automatic int op_lsb(input int aw);
    return RS_LSB + 2 * aw;
  endfunction
endpackage

// File: rtl/alu_exec_ctrl_gp_regfile.sv
// gp_regfile: register array with two operand read ports, a monitor port and one load/write-back port
module gp_regfile
  import cdecv_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              idle,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] mon_sel,
  output logic [DATA_W-1:0] mon_data
);
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [DATA_W-1:0] regs_d [2**ADDR_W];
  logic              ld_go;
  assign ld_go    = idle && ld_en;
  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign mon_data = regs_q[mon_sel];
  // single write port: a load only happens in IDLE and write-back only in WRITE, load wins if both
  always_comb begin
    regs_d = regs_q;
    if (ld_go || wb_en) regs_d[ld_go ? ld_addr : wb_addr] = ld_go ? ld_data : wb_data;
  end
  // register array, cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: four-cycle execute sequencer feeding an external combinational ALU
module alu_exec_ctrl
  import cdecv_pkg::*;
#(
  parameter int REG_ADDR_W = 2,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [OP_W+2*REG_ADDR_W:0]  instr,
  input  logic                        ld_en,
  input  logic [REG_ADDR_W-1:0]       ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  output logic [OP_W-1:0]             alu_op,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic                        alu_cy,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic [2:0]                  alu_szcy,
  output logic                        done,
  output logic [2:0]                  flags,
  input  logic [REG_ADDR_W-1:0]       mon_sel,
  output logic [DATA_W-1:0]           mon_data
);
  localparam int IW     = OP_W + 2 * REG_ADDR_W + 1;
  localparam int RD_LSB = rd_lsb(REG_ADDR_W);
  localparam int OP_LSB = op_lsb(REG_ADDR_W);
  state_e                  state_q, state_d;
  logic [IW-1:0]           instr_q, instr_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [DATA_W-1:0]       a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]              szcy_q, szcy_d, flags_q, flags_d;
  logic [REG_ADDR_W-1:0]   rd_addr, rs_addr;
  logic [DATA_W-1:0]       rd_data, rs_data;
  logic                    accept, wb_we;
  assign rd_addr     = instr_q[RD_LSB +: REG_ADDR_W];
  assign rs_addr     = instr_q[RS_LSB +: REG_ADDR_W];
  assign instr_ready = reset_n && (state_q == IDLE) && !ld_en;
  assign accept      = instr_valid && instr_ready;
  assign wb_we       = (state_q == WRITE) && instr_q[WB_BIT];
  assign done        = state_q == WRITE;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_cy      = flags_q[FLAG_CY];
  assign flags       = flags_q;
  gp_regfile #(.ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .idle     (state_q == IDLE),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_en    (wb_we),
    .wb_addr  (rd_addr),
    .wb_data  (result_q),
    .ra_addr  (rd_addr),
    .ra_data  (rd_data),
    .rb_addr  (rs_addr),
    .rb_data  (rs_data),
    .mon_sel  (mon_sel),
    .mon_data (mon_data)
  );
  // sequencing: latch on accept, drive ALU after READ, sample ALU after EXEC, commit flags after WRITE
  always_comb begin
    state_d  = state_q == IDLE ? (accept ? READ : IDLE) :
               state_q == READ ? EXEC : state_q == EXEC ? WRITE : IDLE;
    instr_d  = accept ? instr : instr_q;
    op_d     = state_q == READ ? instr_q[OP_LSB +: OP_W] : op_q;
    a_d      = state_q == READ ? rd_data : a_q;
    b_d      = state_q == READ ? rs_data : b_q;
    result_d = state_q == EXEC ? alu_result : result_q;
    szcy_d   = state_q == EXEC ? alu_szcy : szcy_q;
    flags_d  = state_q == WRITE ? szcy_q : flags_q;
  end
  // state and datapath registers; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      szcy_q   <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      szcy_q   <= szcy_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed and randomized checks of the execute sequencer against a reference model
module tb_alu_exec_ctrl;
  import cdecv_pkg::*;
  localparam int AW = 2;
  localparam int IW = 5 + 2 * AW + 1;
  logic          clk = 0, reset_n = 0, instr_valid = 0, ld_en = 0;
  logic          instr_ready, alu_cy, done;
  logic [IW-1:0] instr = '0;
  logic [AW-1:0] ld_addr = '0, mon_sel = '0;
  logic [7:0]    ld_data = '0, alu_a, alu_b, alu_result, mon_data;
  logic [4:0]    alu_op;
  logic [2:0]    alu_szcy, flags;
  int            n_cmp = 0, n_err = 0;
  logic [7:0]    m [4];
  logic [2:0]    mf;

  alu_exec_ctrl #(.REG_ADDR_W(AW), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cy(alu_cy),
    .alu_result(alu_result), .alu_szcy(alu_szcy), .done(done), .flags(flags),
    .mon_sel(mon_sel), .mon_data(mon_data)
  );

  always #10 clk = ~clk;

  // behavioural ALU: returns {S,Z,Cy,result}; Cy is carry out for adds/shift and borrow for subtracts
  function automatic logic [10:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
    int r;
    logic [7:0] y;
    case (op)
      OP_ADD:  r = int'(a) + int'(b);
      OP_ADC:  r = int'(a) + int'(b) + int'(ci);
      OP_SUB:  r = int'(a) - int'(b);
      OP_SBC:  r = int'(a) - int'(b) - int'(ci);
      OP_INC:  r = int'(a) + 1;
      OP_AND:  r = int'(a & b);
      OP_SHL:  r = int'(a) * 2;
      default: r = 0;
    endcase
    y = r[7:0];
    return {y[7], y == 8'h00, (r > 255) || (r < 0), y};
  endfunction

  assign {alu_szcy, alu_result} = alu_f(alu_op, alu_a, alu_b, alu_cy);

  function automatic void model_exec(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic wb);
    logic [10:0] r;
    r = alu_f(op, m[rd], m[rs], mf[0]);
    if (wb) m[rd] = r[7:0];
    mf = r[10:8];
  endfunction

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 0;
    m[a] = d;
  endtask

  // issue one instruction, scramble instr after acceptance, and observe READ/EXEC outputs and done latency
  task automatic do_instr(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic wb,
                          output int lat, output logic cy_r, output logic [4:0] op_x,
                          output logic [7:0] a_x, output logic [7:0] b_x);
    @(negedge clk);
    instr_valid = 1; instr = {op, rd, rs, wb};
    @(posedge clk);
    #1 instr_valid = 0; instr = IW'($urandom);
    lat = 0; cy_r = 1'bx; op_x = 'x; a_x = 'x; b_x = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) cy_r = alu_cy;
      if (k == 2) begin op_x = alu_op; a_x = alu_a; b_x = alu_b; end
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    mf = 3'b000;
    repeat (2) @(negedge clk);
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (flags !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", flags); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== 21'h0) begin n_err++; $display("FAIL reset_alu_out: got op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b); end
    for (int i = 0; i < 4; i++) begin
      mon_sel = 2'(i); #1;
      n_cmp++; if (mon_data !== 8'h00) begin n_err++; $display("FAIL reset_r%0d: got %h want 00", i, mon_data); end
    end
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_load;
    do_load(2'd0, 8'h3C);
    do_load(2'd1, 8'h0F);
    mon_sel = 2'd0; #1;
    n_cmp++; if (mon_data !== 8'h3C) begin n_err++; $display("FAIL load_r0: got %h want 3c", mon_data); end
    mon_sel = 2'd1; #1;
    n_cmp++; if (mon_data !== 8'h0F) begin n_err++; $display("FAIL load_r1: got %h want 0f", mon_data); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b want 1", instr_ready); end
    n_cmp++; if (flags !== 3'b000) begin n_err++; $display("FAIL load_flags: got %b want 000", flags); end
  endtask

  task automatic test_add_carry;
    int lat; logic cy; logic [4:0] o; logic [7:0] a, b;
    do_load(2'd0, 8'hFF);
    do_load(2'd1, 8'h01);
    do_instr(OP_ADD, 2'd0, 2'd1, 1'b1, lat, cy, o, a, b);
    model_exec(OP_ADD, 2'd0, 2'd1, 1'b1);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL add_latency: got %0d want 3", lat); end
    n_cmp++; if ({o, a, b} !== {OP_ADD, 8'hFF, 8'h01}) begin n_err++; $display("FAIL add_operands: got op=%h a=%h b=%h want 08 ff 01", o, a, b); end
    @(posedge clk); #1;
    mon_sel = 2'd0; #1;
    n_cmp++; if (mon_data !== 8'h00) begin n_err++; $display("FAIL add_r0: got %h want 00", mon_data); end
    n_cmp++; if (flags !== 3'b011) begin n_err++; $display("FAIL add_flags: got %b want 011", flags); end
    n_cmp++; if ({done, instr_ready} !== 2'b01) begin n_err++; $display("FAIL add_after: got done=%b ready=%b want 0 1", done, instr_ready); end
  endtask

  task automatic test_adc;
    int lat; logic cy; logic [4:0] o; logic [7:0] a, b;
    do_instr(OP_ADC, 2'd1, 2'd1, 1'b1, lat, cy, o, a, b);
    model_exec(OP_ADC, 2'd1, 2'd1, 1'b1);
    n_cmp++; if (cy !== 1'b1) begin n_err++; $display("FAIL adc_cy_in: got %b want 1", cy); end
    @(posedge clk); #1;
    mon_sel = 2'd1; #1;
    n_cmp++; if (mon_data !== 8'h03) begin n_err++; $display("FAIL adc_r1: got %h want 03", mon_data); end
    n_cmp++; if (flags !== 3'b000) begin n_err++; $display("FAIL adc_flags: got %b want 000", flags); end
  endtask

  task automatic test_compare;
    int lat; logic cy; logic [4:0] o; logic [7:0] a, b;
    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h05);
    do_instr(OP_SUB, 2'd0, 2'd1, 1'b0, lat, cy, o, a, b);
    model_exec(OP_SUB, 2'd0, 2'd1, 1'b0);
    @(posedge clk); #1;
    mon_sel = 2'd0; #1;
    n_cmp++; if (mon_data !== 8'h05) begin n_err++; $display("FAIL cmp_r0: got %h want 05", mon_data); end
    n_cmp++; if (flags !== 3'b010) begin n_err++; $display("FAIL cmp_flags: got %b want 010", flags); end
  endtask

  task automatic test_contention;
    int seen;
    @(negedge clk);
    ld_en = 1; ld_addr = 2'd2; ld_data = 8'hA5;
    instr_valid = 1; instr = {OP_INC, 2'd2, 2'd2, 1'b1};
    #1;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL cont_ready: got %b want 0", instr_ready); end
    @(posedge clk);
    #1 ld_en = 0; instr_valid = 0;
    m[2] = 8'hA5;
    seen = 0;
    repeat (5) begin @(negedge clk); if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL cont_no_exec: got %0d done pulses want 0", seen); end
    mon_sel = 2'd2; #1;
    n_cmp++; if (mon_data !== 8'hA5) begin n_err++; $display("FAIL cont_r2: got %h want a5", mon_data); end
    n_cmp++; if (flags !== mf) begin n_err++; $display("FAIL cont_flags: got %b want %b", flags, mf); end
  endtask

  task automatic test_busy_load;
    @(negedge clk);
    instr_valid = 1; instr = {OP_AND, 2'd0, 2'd2, 1'b1};
    @(posedge clk);
    #1 instr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    ld_en = 1; ld_addr = 2'd3; ld_data = 8'h77;
    @(posedge clk);
    #1 ld_en = 0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_done: got %b want 1", done); end
    model_exec(OP_AND, 2'd0, 2'd2, 1'b1);
    @(posedge clk); #1;
    mon_sel = 2'd3; #1;
    n_cmp++; if (mon_data !== m[3]) begin n_err++; $display("FAIL busy_r3: got %h want %h", mon_data, m[3]); end
    mon_sel = 2'd0; #1;
    n_cmp++; if (mon_data !== m[0]) begin n_err++; $display("FAIL busy_r0: got %h want %h", mon_data, m[0]); end
  endtask

  task automatic test_reset_mid;
    int seen;
    do_load(2'd0, 8'h10);
    do_load(2'd1, 8'h20);
    @(negedge clk);
    instr_valid = 1; instr = {OP_ADD, 2'd0, 2'd1, 1'b1};
    @(posedge clk);
    #1 instr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0;
    #1;
    mon_sel = 2'd0; #1;
    n_cmp++; if (mon_data !== 8'h00) begin n_err++; $display("FAIL rmid_r0: got %h want 00", mon_data); end
    n_cmp++; if ({instr_ready, done, flags} !== 5'b0) begin n_err++; $display("FAIL rmid_ctrl: got ready=%b done=%b flags=%b want 0 0 000", instr_ready, done, flags); end
    n_cmp++; if ({alu_a, alu_b} !== 16'h0) begin n_err++; $display("FAIL rmid_operands: got a=%h b=%h want 00 00", alu_a, alu_b); end
    seen = 0;
    repeat (2) begin @(negedge clk); if (done) seen++; end
    reset_n = 1;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    mf = 3'b000;
    repeat (4) begin @(negedge clk); if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rmid_done: got %0d pulses want 0", seen); end
    n_cmp++; if ({instr_ready, flags} !== 4'b1000) begin n_err++; $display("FAIL rmid_after: got ready=%b flags=%b want 1 000", instr_ready, flags); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] ops [8];
    logic [4:0] op; logic [1:0] rd, rs; logic wb;
    logic [7:0] ea, eb; logic ecy;
    int lat; logic cy; logic [4:0] o; logic [7:0] a, b;
    ops = '{OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_AND, OP_SHL, 5'b00000};
    for (int i = 0; i < 4; i++) do_load(2'(i), 8'($urandom));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) do_load(2'($urandom), 8'($urandom));
      op = ($urandom_range(0, 7) == 7) ? 5'($urandom) : ops[$urandom_range(0, 6)];
      rd = 2'($urandom); rs = 2'($urandom); wb = ($urandom_range(0, 3) != 0);
      ea = m[rd]; eb = m[rs]; ecy = mf[0];
      do_instr(op, rd, rs, wb, lat, cy, o, a, b);
      model_exec(op, rd, rs, wb);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 3", t, lat); end
      n_cmp++; if ({o, a, b, cy} !== {op, ea, eb, ecy}) begin n_err++; $display("FAIL rnd%0d_alu_in: got op=%h a=%h b=%h cy=%b want %h %h %h %b", t, o, a, b, cy, op, ea, eb, ecy); end
      @(posedge clk); #1;
      n_cmp++; if ({flags, instr_ready} !== {mf, 1'b1}) begin n_err++; $display("FAIL rnd%0d_flags: got flags=%b ready=%b want %b 1", t, flags, instr_ready, mf); end
      for (int i = 0; i < 4; i++) begin
        mon_sel = 2'(i); #1;
        n_cmp++; if (mon_data !== m[i]) begin n_err++; $display("FAIL rnd%0d_r%0d: got %h want %h", t, i, mon_data, m[i]); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_add_carry();
    test_adc();
    test_compare();
    test_contention();
    test_busy_load();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage sequencer sitting directly upstream of the 8-bit ALU.
- Owns a small general-purpose register file and the SZCy flag register.
- Accepts one ALU instruction per valid/ready handshake, drives the ALU's aluop, a, b and Cy_in inputs, then captures the ALU's result and SZCy and writes them back.
- Exposes a monitor read port for the board monitor.

Parameters:
- REG_ADDR_W, 2, register address width; register count = 2**REG_ADDR_W (default 4 registers).
- DATA_W, 8, datapath width; fixed at 8 to match the ALU; any other value is unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction this cycle.
- instr  in  5+2*REG_ADDR_W+1  {aluop[4:0], rd, rs, wb_en}; rd is also operand a, rs is operand b.
- ld_en  in  1  direct register load request (monitor/init).
- ld_addr  in  REG_ADDR_W  load target.
- ld_data  in  DATA_W  load value.
- alu_op  out  5  to ALU aluop.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_cy  out  1  to ALU Cy_in; always equals the stored Cy flag.
- alu_result  in  DATA_W  from ALU result.
- alu_szcy  in  3  from ALU {S,Z,Cy}.
- done  out  1  one-cycle pulse when write-back completes.
- flags  out  3  stored {S,Z,Cy}.
- mon_sel  in  REG_ADDR_W  monitor register select.
- mon_data  out  DATA_W  register[mon_sel], combinational.

Behaviour:
- Reset (async, reset_n=0), effective immediately including mid-instruction:
  - State = IDLE.
  - All registers = 0x00; flags = 3'b000.
  - alu_op = 5'b00000, alu_a = alu_b = 0x00.
  - done = 0; instr_ready = 0 while reset_n is low.
  - An in-flight instruction is discarded with no write-back.
- FSM states and transitions:
  - IDLE -> READ on instr_valid && instr_ready.
  - READ -> EXEC -> WRITE -> IDLE unconditionally.
- Ready and acceptance:
  - instr_ready = (state==IDLE) && !ld_en.
  - A load has priority over an instruction in the same cycle.
  - instr is latched only on the accepting edge; later changes to instr are ignored.
- READ:
  - alu_op <= latched aluop.
  - alu_a <= reg[rd], alu_b <= reg[rs]; both are registered outputs.
  - These values are held stable through EXEC and WRITE.
- EXEC: result_q <= alu_result, szcy_q <= alu_szcy. The ALU is purely combinational, so sampling at the end of EXEC gives one full cycle of settle time.
- WRITE:
  - If wb_en=1: reg[rd] <= result_q.
  - flags <= szcy_q always, whether or not wb_en is set (wb_en=0 gives compare/test semantics).
  - done = 1 for this cycle only.
- Latency: accept on edge N; done high during cycle N+3; register and flags visible from edge N+3; instr_ready high again in cycle N+4. Throughput is one instruction per 4 cycles.
- Back-to-back instructions: the second instruction reads the values written by the first, because acceptance only happens in IDLE, after WRITE.
- alu_cy is the stored Cy as it stood when the instruction was accepted. Flags do not change before WRITE, so ADC/SBC use the previous instruction's carry.
- Loads:
  - Honoured only when state==IDLE: reg[ld_addr] <= ld_data on the edge.
  - ld_en outside IDLE is ignored; no queuing.
  - Loads never change flags.
- Undefined aluop values pass through unchanged; the ALU returns 0x00, so Z=1 and the result is written if wb_en=1.
- rd==rs is legal; both operands read the same register.
- mon_data is combinational from the register array and reflects a write starting the cycle after the write edge.

Decomposition:
- Shared package (cdecv_pkg):
  - ALU opcode constants (OP_ADD=5'b01000, OP_ADC=5'b01010, OP_SUB=5'b01011, OP_SBC=5'b01101, OP_INC=5'b01110, OP_AND=5'b10000, OP_SHL=5'b11011, ...).
  - FSM state encoding.
  - instr field offsets.
  - Flag bit indices S=2, Z=1, Cy=0.
- One natural sub-module: gp_regfile.
  - Two combinational read ports plus the monitor read port.
  - One synchronous write port, with a mux that gives the load port priority in IDLE.
  - Async reset of all entries to 0x00.
- The FSM and flag register stay in alu_exec_ctrl.

Test Plan:
- Reset and load: reset, load r0=0x3C, r1=0x0F; mon_sel=0 gives 0x3C; instr_ready=1; flags=000.
- ADD with carry-out: r0=0xFF, r1=0x01, ADD rd=0 rs=1 wb_en=1 -> done 3 cycles after accept; r0=0x00; flags=3'b011 (Z=1, Cy=1).
- ADC uses stored carry: after the previous step, ADC r1+r1 (0x01+0x01+Cy=1) -> alu_cy=1 during READ/EXEC; r1=0x03; flags=000.
- Compare only: SUB r0=0x05, r1=0x05, wb_en=0 -> r0 stays 0x05; flags Z=1.
- Load/instruction contention and busy: ld_en and instr_valid in the same IDLE cycle -> load done, instr_ready=0, instr not taken. ld_en during EXEC -> register unchanged.
- Reset mid-operation: assert reset_n=0 in EXEC of ADD r0=0x10+0x20 -> immediately IDLE, r0=0x00, no done pulse, flags=000.
